// File: rtl/dnn_job_scheduler.sv
// Front-end job scheduler for the 4-phase DNN inference core.
// Two requesters are arbitrated round-robin into a small job FIFO. Jobs are
// issued to the core at most once every 4 cycles. The 28 weights live in a
// local register bank. Core results are routed back to the requester that
// owned each job.
module dnn_job_scheduler #(
    parameter int FIFO_DEPTH = 4,
    parameter int CORE_LAT   = 4,
    parameter int WARMUP     = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [19:0]  req0_x,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [19:0]  req1_x,
    input  logic         cfg_valid,
    output logic         cfg_ready,
    input  logic [4:0]   cfg_addr,
    input  logic [4:0]   cfg_data,
    output logic         core_in_ready,
    output logic [19:0]  core_x,
    output logic [139:0] core_w,
    input  logic [16:0]  core_out0,
    input  logic [16:0]  core_out1,
    input  logic         core_out_ready,
    output logic         rsp0_valid,
    output logic         rsp1_valid,
    output logic [16:0]  rsp_out0,
    output logic [16:0]  rsp_out1,
    output logic         err
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int TW = (WARMUP > 3) ? $clog2(WARMUP + 1) : 2;
    localparam int NUM_W = 28;
    localparam logic [CW-1:0] FIFO_FULL   = CW'(FIFO_DEPTH);
    localparam logic [TW-1:0] WARMUP_LAST = TW'(WARMUP - 1);
    localparam logic [TW-1:0] BUSY_LAST   = TW'(2);

    typedef enum logic [1:0] {ST_WARMUP, ST_IDLE, ST_BUSY} state_t;

    state_t              state_q, state_d;
    logic [TW-1:0]       cnt_q, cnt_d;
    logic                accept_en_q;
    logic                rr_q, rr_d;
    logic [20:0]         fifo_q [FIFO_DEPTH];
    logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]       count_q, count_d;
    logic [CORE_LAT-1:0] fl_valid_q, fl_src_q;
    logic                rsp0_valid_q, rsp1_valid_q, err_q;
    logic [16:0]         rsp_out0_q, rsp_out1_q;

    logic        can_accept, grant0, grant1, push, issue, in_flight, cfg_we;
    logic        tail_valid, tail_src;
    logic [20:0] push_data, head;

    // Request side: readiness depends only on registered occupancy, so a pop
    // in the same cycle never makes room for a push.
    assign can_accept = accept_en_q && (count_q != FIFO_FULL) && !cfg_valid;
    assign req0_ready = can_accept && (!req1_valid || !rr_q);
    assign req1_ready = can_accept && (!req0_valid || rr_q);
    assign grant0     = req0_valid && req0_ready;
    assign grant1     = req1_valid && req1_ready;
    assign push       = grant0 || grant1;
    assign push_data  = grant1 ? {1'b1, req1_x} : {1'b0, req0_x};

    // Issue side: a job leaves the FIFO in the same cycle it is pulsed to the core.
    assign head          = fifo_q[rd_ptr_q];
    assign issue         = (state_q == ST_IDLE) && (count_q != '0);
    assign core_in_ready = issue;
    assign core_x        = issue ? head[19:0] : 20'd0;

    assign tail_valid = fl_valid_q[CORE_LAT-1];
    assign tail_src   = fl_src_q[CORE_LAT-1];
    assign in_flight  = |fl_valid_q;

    // Weights only change when nothing is queued, in flight or being issued.
    assign cfg_ready = (state_q == ST_IDLE) && (count_q == '0) && !in_flight;
    assign cfg_we    = cfg_valid && cfg_ready;

    assign rsp0_valid = rsp0_valid_q;
    assign rsp1_valid = rsp1_valid_q;
    assign rsp_out0   = rsp_out0_q;
    assign rsp_out1   = rsp_out1_q;
    assign err        = err_q;

    // Weight bank; addresses beyond the last weight match no register and are dropped.
    for (genvar gi = 0; gi < NUM_W; gi++) begin : g_weight
        logic [4:0] w_q;
        // Load one weight on an accepted write to its index.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)                                 w_q <= 5'd0;
            else if (cfg_we && (cfg_addr == 5'(gi)))    w_q <= cfg_data;
        end
        assign core_w[5*gi +: 5] = w_q;
    end

    // Round-robin preference and FIFO occupancy next-state.
    always_comb begin
        rr_d    = rr_q;
        count_d = count_q;
        if (grant0)      rr_d = 1'b1;
        else if (grant1) rr_d = 1'b0;
        if (push && !issue)      count_d = count_q + CW'(1);
        else if (!push && issue) count_d = count_q - CW'(1);
    end

    // FIFO storage needs no reset: occupancy decides which entries are live.
    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q] <= push_data;
    end

    // FIFO pointers, arbiter pointer and post-reset request enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rr_q        <= 1'b0;
            accept_en_q <= 1'b0;
        end else begin
            if (push)  wr_ptr_q <= wr_ptr_q + PW'(1);
            if (issue) rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q     <= count_d;
            rr_q        <= rr_d;
            accept_en_q <= 1'b1;
        end
    end

    // Issue FSM next-state: warm-up count, then idle/busy spacing of issues.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_WARMUP: begin
                if (cnt_q == WARMUP_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + TW'(1);
                end
            end
            ST_IDLE: begin
                if (issue) begin
                    state_d = ST_BUSY;
                    cnt_d   = '0;
                end
            end
            ST_BUSY: begin
                if (cnt_q == BUSY_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + TW'(1);
                end
            end
            default: begin
                state_d = ST_WARMUP;
                cnt_d   = '0;
            end
        endcase
    end

    // Issue FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_WARMUP;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // In-flight tracker, result routing and sticky unexpected-result flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fl_valid_q   <= '0;
            fl_src_q     <= '0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp_out0_q   <= '0;
            rsp_out1_q   <= '0;
            err_q        <= 1'b0;
        end else begin
            fl_valid_q   <= {fl_valid_q[CORE_LAT-2:0], issue};
            fl_src_q     <= {fl_src_q[CORE_LAT-2:0], head[20]};
            rsp0_valid_q <= core_out_ready && tail_valid && !tail_src;
            rsp1_valid_q <= core_out_ready && tail_valid && tail_src;
            if (core_out_ready && tail_valid) begin
                rsp_out0_q <= core_out0;
                rsp_out1_q <= core_out1;
            end
            if (core_out_ready && !tail_valid) err_q <= 1'b1;
        end
    end

endmodule
